// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues credit-limited word fetches,
// buffers in-order responses and hands {pc, instr} to decode; redirects flush.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        fault
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          fault_q;
  logic [31:0]   buf_pc    [DEPTH];
  logic [31:0]   buf_instr [DEPTH];

  logic [CW:0]   occupancy;
  logic          req_valid_int;
  logic          req_fire;
  logic          rsp_fire;
  logic [CW-1:0] inflight_after_rsp;
  logic [31:0]   rsp_pc;
  logic          push;
  logic          pop;
  logic          redirect_take;
  logic          misaligned;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Credit check counts in-flight and buffered words so every response has a slot.
  assign occupancy          = {1'b0, inflight} + {1'b0, count};
  assign req_valid_int      = (state == RUN) && !redirect_valid &&
                              (occupancy < {1'b0, DEPTH_C});
  assign req_fire           = req_valid_int && imem_req_ready;
  assign rsp_fire           = imem_rsp_valid && (inflight != '0);
  assign inflight_after_rsp = inflight - CW'(rsp_fire);
  // Requests in RUN are consecutive words, so the oldest outstanding one sits inflight words behind pc.
  assign rsp_pc             = pc - (32'(inflight) << 2);
  assign push               = rsp_fire && (state == RUN);
  assign pop                = (count != '0) && dec_ready;
  assign redirect_take      = redirect_valid && (state != HALT);
  assign misaligned         = redirect_pc[1:0] != 2'b00;

  assign imem_req_valid = rst_n && req_valid_int;
  assign imem_req_addr  = rst_n ? pc : '0;
  assign dec_valid      = rst_n && (count != '0);
  assign dec_instr      = rst_n ? buf_instr[head] : '0;
  assign dec_pc         = rst_n ? buf_pc[head] : '0;
  assign fault          = fault_q;

  // Redirect outranks fetch, response push and decode pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      inflight <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      fault_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(rsp_fire);
      if (redirect_take) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
        if (misaligned) begin
          state   <= HALT;
          fault_q <= 1'b1;
        end else begin
          pc    <= redirect_pc;
          state <= (inflight_after_rsp != '0) ? FLUSH : RUN;
        end
      end else begin
        if (req_fire) begin
          pc <= pc + 32'd4;
        end
        if (push) begin
          buf_pc[tail]    <= rsp_pc;
          buf_instr[tail] <= imem_rsp_data;
          tail            <= next_ptr(tail);
        end
        if (pop) begin
          head <= next_ptr(head);
        end
        count <= count + CW'(push) - CW'(pop);
        if ((state == FLUSH) && (inflight_after_rsp == '0)) begin
          state <= RUN;
        end
      end
    end
  end

  a_bounds: assert property (@(posedge clk) disable iff (!rst_n)
                             (inflight <= DEPTH_C) && (count <= DEPTH_C));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer (DEPTH=2, RESET_PC=0) with
// a hand-modelled memory whose responses are written straight into the vectors.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        fault;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fault          (fault)
  );

  typedef struct {
    logic        rst_n;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_addr;
    logic        redir;
    logic [31:0] redir_pc;
    logic        dec_ready;
    logic        e_req_valid;
    logic [31:0] e_addr;
    logic        e_dec_valid;
    logic [31:0] e_dec_pc;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];
  int   tests_run;
  int   tests_failed;
  int   row;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: a distinct word per address.
  function automatic logic [31:0] dat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void add(input logic r, input logic rdy, input logic rv,
                              input logic [31:0] ra, input logic rd,
                              input logic [31:0] rpc, input logic dr,
                              input logic erv, input logic [31:0] ea,
                              input logic edv, input logic [31:0] edpc,
                              input logic ef);
    vec_t v;
    v.rst_n = r;      v.req_ready = rdy;  v.rsp_valid = rv;  v.rsp_addr = ra;
    v.redir = rd;     v.redir_pc = rpc;   v.dec_ready = dr;
    v.e_req_valid = erv; v.e_addr = ea;   v.e_dec_valid = edv;
    v.e_dec_pc = edpc;   v.e_fault = ef;
    vecs.push_back(v);
  endfunction

  task automatic checkField(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n          = v.rst_n;
    imem_req_ready = v.req_ready;
    imem_rsp_valid = v.rsp_valid;
    imem_rsp_data  = v.rsp_valid ? dat(v.rsp_addr) : 32'h0;
    redirect_valid = v.redir;
    redirect_pc    = v.redir_pc;
    dec_ready      = v.dec_ready;
  endtask

  task automatic checkOutput(input vec_t v);
    #1;
    checkField("req_valid", 32'(imem_req_valid), 32'(v.e_req_valid));
    checkField("req_addr", imem_req_addr, v.e_addr);
    checkField("dec_valid", 32'(dec_valid), 32'(v.e_dec_valid));
    checkField("fault", 32'(fault), 32'(v.e_fault));
    if (!v.rst_n) begin
      checkField("dec_pc_reset", dec_pc, 32'h0);
      checkField("dec_instr_reset", dec_instr, 32'h0);
    end else if (v.e_dec_valid) begin
      checkField("dec_pc", dec_pc, v.e_dec_pc);
      checkField("dec_instr", dec_instr, dat(v.e_dec_pc));
    end
  endtask

  initial begin
    vec_t h;
    bit   seen;
    tests_run      = 0;
    tests_failed   = 0;
    row            = 0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;

    // Reset, then 1-cycle memory with dec_ready=1.
    add(0,1,0,0,0,0,1, 0,32'h0,0,0,0);
    add(0,1,0,0,0,0,1, 0,32'h0,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'h0,0,0,0);
    add(1,1,1,32'h0,0,0,1, 1,32'h4,0,0,0);
    add(1,1,1,32'h4,0,0,1, 0,32'h8,1,32'h0,0);
    add(1,1,0,0,0,0,1, 1,32'h8,1,32'h4,0);
    add(1,1,1,32'h8,0,0,1, 1,32'hC,0,0,0);
    add(1,1,1,32'hC,0,0,1, 0,32'h10,1,32'h8,0);
    // Decode stalls: buffer fills to DEPTH, requests stop, head held.
    add(1,1,0,0,0,0,0, 1,32'h10,1,32'hC,0);
    add(1,1,1,32'h10,0,0,0, 0,32'h14,1,32'hC,0);
    for (int i = 0; i < 8; i++) add(1,1,0,0,0,0,0, 0,32'h14,1,32'hC,0);
    // Resume drains in order.
    add(1,1,0,0,0,0,1, 0,32'h14,1,32'hC,0);
    add(1,1,0,0,0,0,1, 1,32'h14,1,32'h10,0);
    add(1,1,1,32'h14,0,0,1, 1,32'h18,0,0,0);
    add(1,1,1,32'h18,0,0,1, 0,32'h1C,1,32'h14,0);
    add(1,1,0,0,0,0,1, 1,32'h1C,1,32'h18,0);
    // Two fetches outstanding, redirect to 0x100, both responses dropped.
    add(1,1,0,0,0,0,1, 1,32'h20,0,0,0);
    add(1,1,0,0,1,32'h100,1, 0,32'h24,0,0,0);
    add(1,1,1,32'h1C,0,0,1, 0,32'h100,0,0,0);
    add(1,1,1,32'h20,0,0,1, 0,32'h100,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'h100,0,0,0);
    add(1,1,1,32'h100,0,0,1, 1,32'h104,0,0,0);
    add(1,1,1,32'h104,0,0,1, 0,32'h108,1,32'h100,0);
    add(1,1,0,0,0,0,1, 1,32'h108,1,32'h104,0);
    add(1,1,1,32'h108,0,0,1, 1,32'h10C,0,0,0);
    // Redirect together with a response and a pop: nothing stale survives.
    add(1,1,1,32'h10C,1,32'h200,1, 0,32'h110,1,32'h108,0);
    add(1,1,0,0,0,0,1, 1,32'h200,0,0,0);
    add(1,1,1,32'h200,0,0,1, 1,32'h204,0,0,0);
    add(1,1,1,32'h204,0,0,1, 0,32'h208,1,32'h200,0);
    add(1,1,0,0,0,0,1, 1,32'h208,1,32'h204,0);
    // Misaligned redirect: HALT with sticky fault, later redirects ignored.
    add(1,1,1,32'h208,1,32'h102,1, 0,32'h20C,0,0,0);
    add(1,1,0,0,0,0,1, 0,32'h20C,0,0,1);
    add(1,1,0,0,1,32'h300,1, 0,32'h20C,0,0,1);
    add(1,1,0,0,0,0,1, 0,32'h20C,0,0,1);
    add(0,1,0,0,0,0,1, 0,32'h0,0,0,0);
    add(0,1,0,0,0,0,1, 0,32'h0,0,0,0);
    // PC wrap past 0xFFFF_FFFC, then reset in the middle of a fetch.
    add(1,1,0,0,1,32'hFFFF_FFF8,1, 0,32'h0,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'hFFFF_FFF8,0,0,0);
    add(1,1,1,32'hFFFF_FFF8,0,0,1, 1,32'hFFFF_FFFC,0,0,0);
    add(1,1,1,32'hFFFF_FFFC,0,0,1, 0,32'h0,1,32'hFFFF_FFF8,0);
    add(1,1,0,0,0,0,1, 1,32'h0,1,32'hFFFF_FFFC,0);
    add(0,1,1,32'h0,0,0,1, 0,32'h0,0,0,0);
    add(1,1,0,0,0,0,1, 1,32'h0,0,0,0);
    add(1,1,1,32'h0,0,0,1, 1,32'h4,0,0,0);
    add(1,1,1,32'h4,0,0,1, 0,32'h8,1,32'h0,0);
    add(1,1,0,0,0,0,1, 1,32'h8,1,32'h4,0);

    foreach (vecs[i]) begin
      row = i;
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Redirect, then redirect again while still flushing: last target wins.
    row = 1000;
    h = '{1,1,0,0,1,32'h40,1, 0,32'hC,0,0,0};
    applyStimulus(h); checkOutput(h);
    row = 1001;
    h = '{1,1,0,0,1,32'h80,1, 0,32'h40,0,0,0};
    applyStimulus(h); checkOutput(h);
    row = 1002;
    h = '{1,1,1,32'h8,0,0,1, 0,32'h80,0,0,0};
    applyStimulus(h); checkOutput(h);
    row = 1003;
    h = '{1,1,0,0,0,0,1, 1,32'h80,0,0,0};
    applyStimulus(h); checkOutput(h);
    row = 1004;
    h = '{1,0,1,32'h80,0,0,0, 1,32'h84,0,0,0};
    applyStimulus(h); checkOutput(h);

    // Wait a bounded number of cycles for the redirected word to reach decode.
    row  = 1005;
    seen = 1'b0;
    h    = '{1,0,0,0,0,0,0, 1,32'h84,1,32'h80,0};
    for (int i = 0; i < 4 && !seen; i++) begin
      applyStimulus(h);
      #1;
      seen = dec_valid;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("[TB] FAIL dec_valid_timeout: got 0 after 4 cycles, expected 1");
    end else begin
      checkField("dec_pc_after_flush", dec_pc, 32'h80);
      checkField("dec_instr_after_flush", dec_instr, dat(32'h80));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
